// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: owns the PC, registers ROM words for decode, resolves jumps, waits on branches, parks on halt.
// Optional build macro FETCH_SINGLE_STEP_EN adds a step_i input that gates each FETCH-state issue.
module instr_fetch_seq #(
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       DATA_W    = 10,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [3:0]        JMP_OPC   = 4'b1000,
    parameter logic [2:0]        BR_OPC    = 3'b101,
    parameter logic [DATA_W-1:0] HALT_WORD = 10'b0010000010
) (
    input  logic              clk_i,
    input  logic              rst_ni,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic              step_i,
`endif
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    input  logic              br_valid_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              restart_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halted_o
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_BR_WAIT = 2'd1,
        S_HALT    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                instr_valid_q, instr_valid_d;
    logic                halted_q, halted_d;

    logic                step_ok;
    logic                slot_free;
    logic                fetch_go;
    logic                is_jmp;
    logic                is_halt;
    logic                is_br;
    logic [ADDR_W-1:0]   jmp_tgt;
    logic [ADDR_W-1:0]   pc_inc;

`ifdef FETCH_SINGLE_STEP_EN
    assign step_ok = step_i;
`else
    assign step_ok = 1'b1;
`endif

    // Word decode is on the live ROM output: the ROM answers in the same cycle as pc.
    assign slot_free = !instr_valid_q || instr_ready_i;
    assign fetch_go  = (state_q == S_FETCH) && slot_free && step_ok;
    assign is_jmp    = rom_data_i[DATA_W-1 -: 4] == JMP_OPC;
    assign is_halt   = rom_data_i == HALT_WORD;
    assign is_br     = rom_data_i[DATA_W-1 -: 3] == BR_OPC;
    assign jmp_tgt   = {{(ADDR_W-6){1'b0}}, rom_data_i[5:0]};
    assign pc_inc    = pc_q + ADDR_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (fetch_go && !is_jmp) begin
                    if (is_halt) begin
                        state_d = S_HALT;
                    end else if (is_br) begin
                        state_d = S_BR_WAIT;
                    end
                end
            end
            S_BR_WAIT: begin
                if (br_valid_i) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                if (restart_i) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q && !instr_ready_i;
        case (state_q)
            S_FETCH: begin
                if (fetch_go) begin
                    if (is_jmp) begin
                        pc_d = jmp_tgt;
                    end else begin
                        instr_d       = rom_data_i;
                        instr_valid_d = 1'b1;
                        if (!is_halt) begin
                            pc_d = pc_inc;
                        end
                    end
                end
            end
            S_BR_WAIT: begin
                // Not-taken keeps pc, which already points past the branch.
                if (br_valid_i && br_taken_i) begin
                    pc_d = br_target_i;
                end
            end
            S_HALT: begin
                if (restart_i) begin
                    pc_d = RESET_PC;
                end
            end
            default: pc_d = RESET_PC;
        endcase
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    always_comb begin
        rom_addr_o    = pc_q;
        pc_o          = pc_q;
        instr_o       = instr_q;
        instr_valid_o = instr_valid_q;
        halted_o      = halted_q;
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed scenarios plus randomized traffic against a behavioural model.
module tb_instr_fetch_seq;

    localparam logic [9:0] HALT_W = 10'b0010000010;
    localparam logic [9:0] BR5_W  = 10'b1010110011;
    localparam logic [9:0] JMP9_W = 10'b1000001001;
    localparam int M_FETCH = 0;
    localparam int M_BR    = 1;
    localparam int M_HALT  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] rom_addr;
    logic [9:0] rom_data;
    logic [9:0] instr;
    logic       instr_valid;
    logic       instr_ready = 1'b1;
    logic       br_valid = 1'b0;
    logic       br_taken = 1'b0;
    logic [9:0] br_target = '0;
    logic       restart = 1'b0;
    logic [9:0] pc;
    logic       halted;

    logic [9:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [9:0] m_pc = '0;
    logic [9:0] m_instr = '0;
    logic       m_vld = 1'b0;
    logic       m_halted = 1'b0;
    int         m_mode = M_FETCH;

    always #5 clk = ~clk;

    assign rom_data = mem[rom_addr];

    instr_fetch_seq dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
`ifdef FETCH_SINGLE_STEP_EN
        .step_i        (1'b1),
`endif
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .br_valid_i    (br_valid),
        .br_taken_i    (br_taken),
        .br_target_i   (br_target),
        .restart_i     (restart),
        .pc_o          (pc),
        .halted_o      (halted)
    );

    // Plain word at address i: top bits 011 keep it clear of jump/branch/halt codes.
    function automatic logic [9:0] plain(input int i);
        logic [9:0] v;
        v = 10'(i);
        return {3'b011, v[6:0]};
    endfunction

    task automatic init_rom();
        for (int i = 0; i < 1024; i++) mem[i] = plain(i);
    endtask

    // Behavioural model of one clock edge, using the inputs presented this cycle.
    task automatic model_step();
        logic [9:0] w;
        bit free;
        if (!rst_n) begin
            m_pc = '0; m_instr = '0; m_vld = 1'b0; m_halted = 1'b0; m_mode = M_FETCH;
            return;
        end
        free = !m_vld || instr_ready;
        if (instr_ready) m_vld = 1'b0;
        if (m_mode == M_FETCH) begin
            if (free) begin
                w = mem[m_pc];
                if (w[9:6] == 4'b1000) begin
                    m_pc = {4'b0000, w[5:0]};
                end else begin
                    m_instr = w;
                    m_vld = 1'b1;
                    if (w == HALT_W) begin
                        m_mode = M_HALT;
                    end else begin
                        m_pc = m_pc + 10'd1;
                        if (w[9:7] == 3'b101) m_mode = M_BR;
                    end
                end
            end
        end else if (m_mode == M_BR) begin
            if (br_valid) begin
                if (br_taken) m_pc = br_target;
                m_mode = M_FETCH;
            end
        end else begin
            if (restart) begin
                m_pc = '0;
                m_mode = M_FETCH;
            end
        end
        m_halted = (m_mode == M_HALT);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; instr_ready = 1'b1; br_valid = 1'b0; br_taken = 1'b0;
        br_target = '0; restart = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        init_rom();
        do_reset();
        n_tests++; if (pc !== 10'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", pc); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_tests++; if (instr !== 10'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    endtask

    task automatic test_straight();
        init_rom();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (instr !== mem[k] || instr_valid !== 1'b1 || pc !== 10'(k + 1)) begin
                n_fail++;
                $display("FAIL straight_%0d: instr=%h vld=%b pc=%0d want instr=%h vld=1 pc=%0d",
                         k, instr, instr_valid, pc, mem[k], k + 1);
            end
        end
    endtask

    task automatic test_jump();
        init_rom();
        mem[7] = JMP9_W;
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            tick();
            n_tests++;
            if (instr_valid === 1'b1 && instr === JMP9_W) begin
                n_fail++; $display("FAIL jump_issued: cycle %0d instr=%h", k, instr);
            end
            if (k == 8) begin
                n_tests++;
                if (instr_valid !== 1'b0 || pc !== 10'd9) begin
                    n_fail++; $display("FAIL jump_bubble: vld=%b pc=%0d want vld=0 pc=9", instr_valid, pc);
                end
            end
            if (k == 9) begin
                n_tests++;
                if (instr_valid !== 1'b1 || instr !== mem[9]) begin
                    n_fail++; $display("FAIL jump_next: vld=%b instr=%h want vld=1 instr=%h", instr_valid, instr, mem[9]);
                end
            end
        end
    endtask

    task automatic test_branch(input bit taken, input int exp_addr);
        init_rom();
        mem[5] = BR5_W;
        do_reset();
        repeat (6) tick();
        n_tests++;
        if (instr !== BR5_W || pc !== 10'd6) begin
            n_fail++; $display("FAIL br_issue: instr=%h pc=%0d want instr=%h pc=6", instr, pc, BR5_W);
        end
        repeat (2) begin
            tick();
            n_tests++;
            if (pc !== 10'd6 || instr_valid !== 1'b0) begin
                n_fail++; $display("FAIL br_wait: pc=%0d vld=%b want pc=6 vld=0", pc, instr_valid);
            end
        end
        br_valid = 1'b1; br_taken = taken; br_target = 10'd8;
        tick();
        br_valid = 1'b0; br_taken = 1'b0;
        n_tests++;
        if (pc !== 10'(exp_addr)) begin
            n_fail++; $display("FAIL br_resolve_%0d: pc=%0d want %0d", taken, pc, exp_addr);
        end
        tick();
        n_tests++;
        if (instr !== mem[exp_addr] || instr_valid !== 1'b1) begin
            n_fail++; $display("FAIL br_next_%0d: instr=%h vld=%b want %h vld=1", taken, instr, instr_valid, mem[exp_addr]);
        end
    endtask

    task automatic test_stall();
        init_rom();
        do_reset();
        repeat (3) tick();
        instr_ready = 1'b0;
        repeat (3) begin
            tick();
            n_tests++;
            if (instr !== mem[2] || pc !== 10'd3 || instr_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold: instr=%h pc=%0d vld=%b want %h pc=3 vld=1", instr, pc, instr_valid, mem[2]);
            end
        end
        instr_ready = 1'b1;
        tick();
        n_tests++;
        if (instr !== mem[3] || pc !== 10'd4) begin
            n_fail++; $display("FAIL stall_release: instr=%h pc=%0d want %h pc=4", instr, pc, mem[3]);
        end
    endtask

    task automatic test_halt();
        init_rom();
        mem[47] = HALT_W;
        do_reset();
        repeat (48) tick();
        n_tests++;
        if (instr !== HALT_W || halted !== 1'b1 || pc !== 10'd47) begin
            n_fail++; $display("FAIL halt_issue: instr=%h halted=%b pc=%0d want %h 1 47", instr, halted, pc, HALT_W);
        end
        br_valid = 1'b1; br_taken = 1'b1; br_target = 10'd300;
        repeat (10) begin
            tick();
            n_tests++;
            if (pc !== 10'd47 || halted !== 1'b1 || instr_valid !== 1'b0) begin
                n_fail++; $display("FAIL halt_park: pc=%0d halted=%b vld=%b want 47 1 0", pc, halted, instr_valid);
            end
        end
        br_valid = 1'b0; br_taken = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_tests++;
        if (pc !== 10'd0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_restart: pc=%0d halted=%b want 0 0", pc, halted);
        end
        tick();
        n_tests++;
        if (instr !== mem[0] || pc !== 10'd1 || instr_valid !== 1'b1) begin
            n_fail++; $display("FAIL halt_resume: instr=%h pc=%0d want %h pc=1", instr, pc, mem[0]);
        end
    endtask

    task automatic test_reset_in_brwait();
        init_rom();
        mem[5] = BR5_W;
        do_reset();
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (pc !== 10'd0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL brwait_reset: pc=%0d vld=%b halted=%b want 0 0 0", pc, instr_valid, halted);
        end
        rst_n = 1'b1;
        br_valid = 1'b1; br_taken = 1'b1; br_target = 10'd100;
        tick();
        br_valid = 1'b0; br_taken = 1'b0;
        n_tests++;
        if (pc !== 10'd1 || instr !== mem[0]) begin
            n_fail++; $display("FAIL late_br_ignored: pc=%0d instr=%h want pc=1 instr=%h", pc, instr, mem[0]);
        end
    endtask

    task automatic test_wrap();
        init_rom();
        mem[5] = BR5_W;
        do_reset();
        repeat (6) tick();
        br_valid = 1'b1; br_taken = 1'b1; br_target = 10'd1023;
        tick();
        br_valid = 1'b0; br_taken = 1'b0;
        n_tests++;
        if (pc !== 10'd1023) begin
            n_fail++; $display("FAIL wrap_target: pc=%0d want 1023", pc);
        end
        tick();
        n_tests++;
        if (pc !== 10'd0 || instr !== mem[1023]) begin
            n_fail++; $display("FAIL wrap_pc: pc=%0d instr=%h want pc=0 instr=%h", pc, instr, mem[1023]);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 1024; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5)       mem[i] = {4'b1000, 6'($urandom)};
            else if (r < 11) mem[i] = {3'b101, 7'($urandom)};
            else if (r < 13) mem[i] = HALT_W;
            else             mem[i] = {3'b011, 7'($urandom)};
        end
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            br_valid    = ($urandom_range(0, 2) == 0);
            br_taken    = 1'($urandom);
            br_target   = 10'($urandom);
            restart     = ($urandom_range(0, 7) == 0);
            rst_n       = ($urandom_range(0, 299) != 0);
            tick();
            n_tests++;
            if (pc !== m_pc) begin
                n_fail++; $display("FAIL rand_pc: cycle %0d got %0d want %0d", c, pc, m_pc);
            end
            n_tests++;
            if (instr_valid !== m_vld) begin
                n_fail++; $display("FAIL rand_valid: cycle %0d got %b want %b", c, instr_valid, m_vld);
            end
            n_tests++;
            if (instr !== m_instr) begin
                n_fail++; $display("FAIL rand_instr: cycle %0d got %h want %h", c, instr, m_instr);
            end
            n_tests++;
            if (halted !== m_halted) begin
                n_fail++; $display("FAIL rand_halted: cycle %0d got %b want %b", c, halted, m_halted);
            end
        end
        rst_n = 1'b1; br_valid = 1'b0; restart = 1'b0; instr_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_rom();
        test_reset();
        test_straight();
        test_jump();
        test_branch(1'b1, 8);
        test_branch(1'b0, 6);
        test_stall();
        test_halt();
        test_reset_in_brwait();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
